// File: rtl/axi_slave_wr_push_ctrl_pkg.sv
// Shared types and default widths for the AXI slave write-request push controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_slave_wr_push_ctrl_pkg;

  localparam int DEF_ID_WIDTH    = 4;
  localparam int DEF_ADDR_WIDTH  = 64;
  localparam int DEF_LEN_WIDTH   = 8;
  localparam int DEF_DATA_WIDTH  = 256;
  localparam int DEF_USER_WIDTH  = 8;
  localparam int DEF_MAX_OUTSTD  = 8;
  localparam int SIZE_WIDTH      = 3;
  localparam int BURST_WIDTH     = 2;

  // AW FIFO entry layout at the default widths; the top packs in the same order.
  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]   id;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_LEN_WIDTH-1:0]  len;
    logic [SIZE_WIDTH-1:0]     size;
    logic [BURST_WIDTH-1:0]    burst;
    logic [DEF_USER_WIDTH-1:0] user;
  } aw_push_t;

  // W FIFO entry layout at the default widths; last is the corrected last flag.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]   data;
    logic [DEF_DATA_WIDTH/8-1:0] strb;
    logic                        last;
  } w_push_t;

  typedef enum logic {W_IDLE, W_DATA} w_state_e;

  function automatic int aw_push_width(int id_w, int addr_w, int len_w, int user_w);
    return id_w + addr_w + len_w + SIZE_WIDTH + BURST_WIDTH + user_w;
  endfunction

endpackage

// File: rtl/axi_slave_wr_push_ctrl_len_queue.sv
// Burst-length queue between the AW and W paths: synchronous FIFO, first-word-fall-through read.
// Latency: a pushed entry is visible on dout the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
// Ports: ACLK/ARESETn clock and sync active-low reset; push/din write; pop/dout read; empty/full status.
module axi_len_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi_slave_wr_push_ctrl.sv
// AXI slave write-request push controller: AW/W handshakes into the downstream AW/W FIFOs, outstanding cap, WLAST repair.
// Latency: AW and W pushes in the handshake cycle; first W beat of a burst is accepted 1 cycle after its AW; wlast_err 1 cycle after the beat.
// Backpressure: AWREADY drops on aw_fifo_full or outstanding cap; WREADY drops on w_fifo_full or when no burst length is loaded.
// Ports: ACLK/ARESETn; AW* and W* slave channels; aw_fifo_full/aw_push/aw_push_data and w_fifo_full/w_push/w_push_data
//        downstream FIFO write side; b_done response pulse; outstanding count; wlast_err violation pulse.
module axi_slave_wr_push_ctrl
  import axi_slave_wr_push_ctrl_pkg::*;
#(
  parameter int ID_WIDTH        = DEF_ID_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH       = DEF_LEN_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int USER_WIDTH      = DEF_USER_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTD
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [LEN_WIDTH-1:0]    AWLEN,
  input  logic [SIZE_WIDTH-1:0]   AWSIZE,
  input  logic [BURST_WIDTH-1:0]  AWBURST,
  input  logic [USER_WIDTH-1:0]   AWUSER,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic                    aw_fifo_full,
  output logic                    aw_push,
  output logic [aw_push_width(ID_WIDTH, ADDR_WIDTH, LEN_WIDTH, USER_WIDTH)-1:0] aw_push_data,
  input  logic                    w_fifo_full,
  output logic                    w_push,
  output logic [DATA_WIDTH+DATA_WIDTH/8:0] w_push_data,
  input  logic                    b_done,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                    wlast_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  w_state_e             w_state;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [LEN_WIDTH-1:0] beat_len;
  logic                 aw_hs;
  logic                 w_hs;
  logic                 b_dec;
  logic                 exp_last;
  logic                 take_next;
  logic                 bypass;
  logic                 q_push;
  logic                 q_pop;
  logic                 q_empty;
  logic                 q_full;
  logic [LEN_WIDTH-1:0] q_dout;
  logic [LEN_WIDTH-1:0] next_len;

  // ---------------- AW path ----------------
  assign AWREADY      = ARESETn && !aw_fifo_full && (outstanding < MAX_CNT);
  assign aw_hs        = AWVALID && AWREADY;
  assign aw_push      = aw_hs;
  assign aw_push_data = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWUSER};

  // A response with nothing outstanding is dropped rather than underflowing.
  assign b_dec = b_done && (outstanding != '0);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      outstanding <= '0;
    end else if (aw_hs && !b_dec) begin
      outstanding <= outstanding + 1'b1;
    end else if (!aw_hs && b_dec) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  // ---------------- W path ----------------
  assign exp_last    = (beat_cnt == beat_len);
  assign WREADY      = ARESETn && (w_state == W_DATA) && !w_fifo_full;
  assign w_hs        = WVALID && WREADY;
  assign w_push      = w_hs;
  assign w_push_data = {WDATA, WSTRB, exp_last};

  // The FSM wants a new length when idle or when the current burst closes.
  // If the queue is empty but an AW is handshaking right now, its AWLEN is
  // taken straight from the port so the first beat can land next cycle.
  assign take_next = (w_state == W_IDLE) || (w_hs && exp_last);
  assign q_pop     = take_next && !q_empty;
  assign bypass    = take_next && q_empty && aw_hs;
  assign q_push    = aw_hs && !bypass;
  assign next_len  = q_empty ? AWLEN : q_dout;

  axi_len_queue #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (LEN_WIDTH)
  ) u_len_queue (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .push    (q_push),
    .pop     (q_pop),
    .din     (AWLEN),
    .dout    (q_dout),
    .empty   (q_empty),
    .full    (q_full)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state   <= W_IDLE;
      beat_cnt  <= '0;
      beat_len  <= '0;
      wlast_err <= 1'b0;
    end else begin
      // Either flavour of WLAST disagreement flags one pulse per offending beat.
      wlast_err <= w_hs && (WLAST != exp_last);
      if (take_next) begin
        if (!q_empty || aw_hs) begin
          w_state  <= W_DATA;
          beat_len <= next_len;
          beat_cnt <= '0;
        end else begin
          w_state  <= W_IDLE;
        end
      end else if (w_hs) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule
